// File: rtl/fir_decim.sv
// Decimating FIR low-pass stage: one output per DECIM accepted samples, one MAC per clock.
// Optional feature macro: FIR_DECIM_SAT_EN (widened accumulator, saturated output).
module fir_decim #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned NUM_TAPS   = 32,
    parameter int unsigned DECIM      = 8,
    parameter int unsigned QUANT_BITS = 10,
    parameter logic signed [DATA_SIZE-1:0] COEFF [NUM_TAPS] = '{default: DATA_SIZE'(32)}
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] x_in,
    output logic                        x_in_rd_en,
    input  logic                        x_in_empty,
    output logic signed [DATA_SIZE-1:0] y_out,
    output logic                        out_wr_en,
    input  logic                        out_full
);

    localparam int unsigned TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PROD_W = 2 * DATA_SIZE;
`ifdef FIR_DECIM_SAT_EN
    localparam int unsigned ACC_W  = DATA_SIZE + $clog2(NUM_TAPS);
`else
    localparam int unsigned ACC_W  = DATA_SIZE;
`endif

    typedef enum logic [1:0] {LOAD, MAC, WRITE} state_t;

    state_t                      state, state_nxt;
    logic signed [DATA_SIZE-1:0] history [NUM_TAPS];
    logic        [CNT_W-1:0]     decim_cnt;
    logic        [TAP_W-1:0]     tap_idx;
    logic signed [ACC_W-1:0]     acc;

    logic signed [PROD_W-1:0]    hist_ext, coef_ext, prod, term_full;
    logic signed [DATA_SIZE-1:0] term;
    logic signed [ACC_W-1:0]     acc_term;
    logic signed [DATA_SIZE-1:0] y_sat;
    logic                        last_decim, last_tap;

    assign last_decim = (decim_cnt == CNT_W'(DECIM - 1));
    assign last_tap   = (tap_idx == TAP_W'(NUM_TAPS - 1));

    // Current tap product, dequantized symmetrically so small negatives round toward zero
    always_comb begin
        hist_ext = PROD_W'(history[tap_idx]);
        coef_ext = PROD_W'(COEFF[tap_idx]);
        prod     = hist_ext * coef_ext;
        if (prod < 0) begin
            term_full = -((-prod) >>> QUANT_BITS);
        end else begin
            term_full = prod >>> QUANT_BITS;
        end
        term     = DATA_SIZE'(term_full);
        acc_term = ACC_W'(term);
    end

    // Output value: plain wrap, or clamp of the wide accumulator when saturation is built in
    always_comb begin
        y_sat = acc[DATA_SIZE-1:0];
`ifdef FIR_DECIM_SAT_EN
        if (!((&acc[ACC_W-1:DATA_SIZE-1]) || !(|acc[ACC_W-1:DATA_SIZE-1]))) begin
            y_sat = acc[ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                 : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
`endif
    end

    // Next state and handshake strobes; pop is suppressed while reset is held
    always_comb begin
        state_nxt  = state;
        x_in_rd_en = 1'b0;
        out_wr_en  = 1'b0;
        y_out      = '0;
        case (state)
            LOAD: begin
                if (!x_in_empty && reset) begin
                    x_in_rd_en = 1'b1;
                    if (last_decim) begin
                        state_nxt = MAC;
                    end
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    y_out     = y_sat;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State, sample history, decimation counter and accumulator
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            decim_cnt <= '0;
            tap_idx   <= '0;
            acc       <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                history[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    if (x_in_rd_en) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) begin
                            history[k] <= history[k-1];
                        end
                        history[0] <= x_in;
                        if (last_decim) begin
                            decim_cnt <= '0;
                            acc       <= '0;
                            tap_idx   <= '0;
                        end else begin
                            decim_cnt <= decim_cnt + CNT_W'(1);
                        end
                    end
                end
                MAC: begin
                    acc     <= acc + acc_term;
                    tap_idx <= last_tap ? '0 : tap_idx + TAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: table of streaming vectors plus backpressure,
// mid-MAC reset and overflow sequences.
module tb_fir_decim;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] x_in = '0;
    logic        x_in_rd_en;
    logic        x_in_empty = 1'b1;
    logic [31:0] y_out;
    logic        out_wr_en;
    logic        out_full = 1'b0;

    logic        rst2 = 1'b0;
    logic        rd2, wr2;
    logic [31:0] y2;
    logic [31:0] x2 = 32'h7FFFFFFF;
    logic        empty2 = 1'b0;
    logic        full2 = 1'b0;

    fir_decim dut (
        .clock(clock), .reset(reset), .x_in(x_in), .x_in_rd_en(x_in_rd_en),
        .x_in_empty(x_in_empty), .y_out(y_out), .out_wr_en(out_wr_en), .out_full(out_full)
    );

    fir_decim #(.COEFF('{default: 32'sd64})) dut2 (
        .clock(clock), .reset(rst2), .x_in(x2), .x_in_rd_en(rd2),
        .x_in_empty(empty2), .y_out(y2), .out_wr_en(wr2), .out_full(full2)
    );

    initial forever #5 clock = ~clock;

    // Requests from the main sequence, applied by the driver at the falling edge
    logic rst_req = 1'b0, full_req = 1'b0, rst2_req = 1'b0, bursty = 1'b0;
    int   cyc = 0;
    int   rd_viol = 0, both_viol = 0;
    logic [31:0] src_q [$];
    int          pop_cyc [$];
    logic [31:0] wr_val [$];
    int          wr_cyc [$];
    logic [31:0] wr2_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream FIFO model and output monitor
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            reset      = rst_req;
            out_full   = full_req;
            rst2       = rst2_req;
            x_in_empty = (src_q.size() == 0) || (bursty && cyc[0]);
            x_in       = (src_q.size() != 0) ? src_q[0] : '0;
            #1;
            if (x_in_rd_en) begin
                if (x_in_empty) rd_viol++;
                else begin
                    void'(src_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
            if (out_wr_en) begin
                wr_val.push_back(y_out);
                wr_cyc.push_back(cyc);
                if (x_in_rd_en) both_viol++;
            end
            if (rd2 && wr2) both_viol++;
            if (wr2 && wr2_q.size() < 8) wr2_q.push_back(y2);
        end
    end

    task automatic step();
        @(negedge clock);
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h (%0d) expected %0h (%0d)", name, act, $signed(act), exp, $signed(exp));
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_val.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_writes", 32'(wr_val.size() >= n), 32'd1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pop_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_pops", 32'(pop_cyc.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst_req = 1'b0;
        step();
        step();
        src_q.delete();
        pop_cyc.delete();
        wr_val.delete();
        wr_cyc.delete();
        rd_viol   = 0;
        both_viol = 0;
        bursty    = 1'b0;
        full_req  = 1'b0;
        rst_req   = 1'b1;
        step();
    endtask

    typedef struct {
        int sample;
        int n_in;
        int burst;
        int n_exp;
        int exp [8];
    } vec_t;

    vec_t tv [6];

    initial begin
        int c8;
        tv[0] = '{1024,  64, 0, 8, '{256, 512, 768, 1024, 1024, 1024, 1024, 1024}};
        tv[1] = '{-1024, 64, 0, 8, '{-256, -512, -768, -1024, -1024, -1024, -1024, -1024}};
        tv[2] = '{-31,    8, 0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
        tv[3] = '{31,     8, 0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
        tv[4] = '{1024,  64, 1, 8, '{256, 512, 768, 1024, 1024, 1024, 1024, 1024}};
        tv[5] = '{2048,  16, 0, 2, '{512, 1024, 0, 0, 0, 0, 0, 0}};

        // Reset state with a sample waiting upstream
        src_q.push_back(32'd1024);
        step();
        step();
        chk("reset_rd_en", 32'(x_in_rd_en), 32'd0);
        chk("reset_wr_en", 32'(out_wr_en), 32'd0);
        chk("reset_y_out", y_out, 32'd0);
        rst2_req = 1'b1;

        // Table-driven streams
        for (int r = 0; r < 6; r++) begin
            do_reset();
            bursty = tv[r].burst[0];
            for (int i = 0; i < tv[r].n_in; i++) src_q.push_back(tv[r].sample);
            wait_writes(tv[r].n_exp, 3000);
            repeat (60) step();
            chk($sformatf("row%0d_count", r), 32'(wr_val.size()), 32'(tv[r].n_exp));
            for (int g = 0; g < tv[r].n_exp && g < wr_val.size(); g++) begin
                chk($sformatf("row%0d_val%0d", r, g), wr_val[g], tv[r].exp[g]);
                if (pop_cyc.size() > 8 * g + 7)
                    chk($sformatf("row%0d_lat%0d", r, g), 32'(wr_cyc[g] - pop_cyc[8 * g + 7]), 32'd33);
            end
            chk($sformatf("row%0d_rd_empty", r), 32'(rd_viol), 32'd0);
            chk($sformatf("row%0d_rd_wr", r), 32'(both_viol), 32'd0);
        end

        // Backpressure: downstream full across WRITE entry for 20 cycles
        do_reset();
        full_req = 1'b1;
        for (int i = 0; i < 16; i++) src_q.push_back(32'd1024);
        wait_pops(8, 100);
        c8 = (pop_cyc.size() >= 8) ? pop_cyc[7] : cyc;
        while (cyc < c8 + 33 + 20) step();
        chk("bp_no_write", 32'(wr_val.size()), 32'd0);
        chk("bp_no_pop", 32'(pop_cyc.size()), 32'd8);
        full_req = 1'b0;
        wait_writes(1, 10);
        if (wr_val.size() >= 1) begin
            chk("bp_val", wr_val[0], 32'd256);
            chk("bp_late", 32'(wr_cyc[0] > c8 + 33 + 19), 32'd1);
        end
        wait_writes(2, 200);
        repeat (40) step();
        chk("bp_count", 32'(wr_val.size()), 32'd2);
        if (wr_val.size() >= 2) chk("bp_val2", wr_val[1], 32'd512);

        // Reset during MAC of the third group aborts it
        do_reset();
        for (int i = 0; i < 24; i++) src_q.push_back(32'd1024);
        wait_pops(24, 300);
        c8 = (pop_cyc.size() >= 24) ? pop_cyc[23] : cyc;
        while (cyc < c8 + 10) step();
        rst_req = 1'b0;
        step();
        chk("rst_mac_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_mac_y_out", y_out, 32'd0);
        step();
        rst_req = 1'b1;
        repeat (60) step();
        chk("rst_mac_count", 32'(wr_val.size()), 32'd2);
        for (int i = 0; i < 8; i++) src_q.push_back(32'd1024);
        wait_writes(3, 200);
        repeat (40) step();
        chk("rst_mac_count2", 32'(wr_val.size()), 32'd3);
        if (wr_val.size() >= 3) chk("rst_mac_val", wr_val[2], 32'd256);

        // Overflow stream on the second instance (coefficients 64, full-scale input)
        chk("ovf_count", 32'(wr2_q.size() >= 4), 32'd1);
        if (wr2_q.size() >= 4) begin
            chk("ovf_first", wr2_q[0], 32'h3FFFFFF8);
`ifdef FIR_DECIM_SAT_EN
            chk("ovf_fourth", wr2_q[3], 32'h7FFFFFFF);
`else
            chk("ovf_fourth", wr2_q[3], 32'hFFFFFFE0);
`endif
        end
        chk("rd_wr_overlap", 32'(both_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
